// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value and commits it to a 16-entry
// register file (R15 is the PC, with no storage) with three bypassed read ports.
module wb_regfile #(
  parameter int unsigned N    = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    ReadData_i,
  input  logic [N-1:0]    AluResult_i,
  input  logic            WBSelect_i,
  input  logic            RF_WE_i,
  input  logic [3:0]      A3_i,
  input  logic [N-1:0]    PC8_i,
  input  logic [3:0]      RA1_i,
  input  logic [3:0]      RA2_i,
  input  logic [3:0]      RA3_i,
  output logic [N-1:0]    RD1_o,
  output logic [N-1:0]    RD2_o,
  output logic [N-1:0]    RD3_o,
  output logic [N-1:0]    WBResult_o,
  output logic            PCWrite_o,
  output logic [CNTW-1:0] WrCount_o
);

  logic [N-1:0]    regs_q [0:14];
  logic [CNTW-1:0] wrcnt_q, wrcnt_d;
  logic [N-1:0]    wb_result;
  logic            wr_active;
  logic [3:0]      ra   [0:2];
  logic [N-1:0]    rd   [0:2];

  assign wb_result  = WBSelect_i ? ReadData_i : AluResult_i;
  assign wr_active  = !RST && RF_WE_i;
  assign WBResult_o = wb_result;
  assign PCWrite_o  = wr_active && (A3_i == 4'hF);
  assign WrCount_o  = wrcnt_q;

  assign wrcnt_d = wr_active ? wrcnt_q + 1'b1 : wrcnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
      wrcnt_q <= '0;
    end else begin
      wrcnt_q <= wrcnt_d;
      if (RF_WE_i && (A3_i != 4'hF)) begin
        regs_q[A3_i] <= wb_result;
      end
    end
  end

  assign ra[0] = RA1_i;
  assign ra[1] = RA2_i;
  assign ra[2] = RA3_i;

  // Lowest priority first so later assignments win: array, bypass, then PC.
  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      rd[k] = '0;
      if (ra[k] != 4'hF) begin
        rd[k] = regs_q[ra[k]];
      end
      if (wr_active && (A3_i == ra[k])) begin
        rd[k] = wb_result;
      end
      if (ra[k] == 4'hF) begin
        rd[k] = PC8_i;
      end
    end
  end

  assign RD1_o = rd[0];
  assign RD2_o = rd[1];
  assign RD3_o = rd[2];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expected values, a negedge
// monitor pops and compares them against the live outputs.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ReadData_i, AluResult_i, PC8_i;
  logic        WBSelect_i, RF_WE_i;
  logic [3:0]  A3_i, RA1_i, RA2_i, RA3_i;
  logic [31:0] RD1_o, RD2_o, RD3_o, WBResult_o;
  logic        PCWrite_o;
  logic [15:0] WrCount_o;

  wb_regfile #(.N(32), .CNTW(16)) dut (
    .CLK(CLK), .RST(RST),
    .ReadData_i(ReadData_i), .AluResult_i(AluResult_i),
    .WBSelect_i(WBSelect_i), .RF_WE_i(RF_WE_i), .A3_i(A3_i),
    .PC8_i(PC8_i), .RA1_i(RA1_i), .RA2_i(RA2_i), .RA3_i(RA3_i),
    .RD1_o(RD1_o), .RD2_o(RD2_o), .RD3_o(RD3_o),
    .WBResult_o(WBResult_o), .PCWrite_o(PCWrite_o), .WrCount_o(WrCount_o)
  );

  always #5 CLK = ~CLK;

  localparam int S_RD1 = 0, S_RD2 = 1, S_RD3 = 2, S_WB = 3, S_PCW = 4, S_CNT = 5;

  string       name_q [$];
  int          sig_q  [$];
  logic [31:0] exp_q  [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model  [0:14];

  task automatic expect_v(input string nm, input int sig, input logic [31:0] v);
    name_q.push_back(nm);
    sig_q.push_back(sig);
    exp_q.push_back(v);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    while (sig_q.size() > 0) begin
      string       nm;
      int          sg;
      logic [31:0] ev, av;
      nm = name_q.pop_front();
      sg = sig_q.pop_front();
      ev = exp_q.pop_front();
      case (sg)
        S_RD1:   av = RD1_o;
        S_RD2:   av = RD2_o;
        S_RD3:   av = RD3_o;
        S_WB:    av = WBResult_o;
        S_PCW:   av = {31'd0, PCWrite_o};
        default: av = {16'd0, WrCount_o};
      endcase
      n_cmp++;
      if (av !== ev) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", nm, av, ev);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; RF_WE_i = 1'b0; WBSelect_i = 1'b0; A3_i = 4'd0;
    ReadData_i = '0; AluResult_i = '0; PC8_i = 32'h48;
    RA1_i = 4'd0; RA2_i = 4'd0; RA3_i = 4'd0;
    step(); step();
    expect_v("reset_rd1", S_RD1, 32'h0);
    expect_v("reset_cnt", S_CNT, 32'h0);
    expect_v("reset_pcw", S_PCW, 32'h0);

    // Preload R3, then reset clears it
    step(); RST = 1'b0; RF_WE_i = 1'b1; A3_i = 4'd3; AluResult_i = 32'h1234; RA1_i = 4'd3;
    expect_v("pre_wb", S_WB, 32'h1234);
    expect_v("pre_bypass", S_RD1, 32'h1234);
    step(); RF_WE_i = 1'b0;
    expect_v("pre_rd1", S_RD1, 32'h1234);
    expect_v("pre_cnt", S_CNT, 32'h1);
    step(); RST = 1'b1;
    expect_v("inrst_pcw", S_PCW, 32'h0);
    expect_v("inrst_rd1", S_RD1, 32'h1234);
    step(); RST = 1'b0;
    expect_v("postrst_rd1", S_RD1, 32'h0);
    expect_v("postrst_cnt", S_CNT, 32'h0);

    // ALU writeback
    step(); RF_WE_i = 1'b1; WBSelect_i = 1'b0; A3_i = 4'd5;
    AluResult_i = 32'hDEADBEEF; ReadData_i = 32'h11111111;
    expect_v("alu_wb", S_WB, 32'hDEADBEEF);
    expect_v("alu_pcw", S_PCW, 32'h0);
    step(); RF_WE_i = 1'b0; RA2_i = 4'd5;
    expect_v("alu_rd2", S_RD2, 32'hDEADBEEF);
    expect_v("alu_cnt", S_CNT, 32'h1);

    // Load writeback with same-cycle bypass on all ports
    step(); RF_WE_i = 1'b1; WBSelect_i = 1'b1; ReadData_i = 32'hCAFEF00D; A3_i = 4'd7;
    RA1_i = 4'd7; RA2_i = 4'd7; RA3_i = 4'd7;
    expect_v("ld_wb", S_WB, 32'hCAFEF00D);
    expect_v("ld_byp1", S_RD1, 32'hCAFEF00D);
    expect_v("ld_byp2", S_RD2, 32'hCAFEF00D);
    expect_v("ld_byp3", S_RD3, 32'hCAFEF00D);
    step(); RF_WE_i = 1'b0; WBSelect_i = 1'b0; AluResult_i = 32'h55;
    expect_v("ld_rd1", S_RD1, 32'hCAFEF00D);
    expect_v("ld_rd3", S_RD3, 32'hCAFEF00D);
    expect_v("ld_cnt", S_CNT, 32'h2);
    expect_v("nowe_wb", S_WB, 32'h55);

    // R15 write: PC load, no array change
    step(); RF_WE_i = 1'b1; A3_i = 4'd15; AluResult_i = 32'h100; PC8_i = 32'h48;
    RA1_i = 4'd15; RA2_i = 4'd5; RA3_i = 4'd7;
    expect_v("r15_pcw", S_PCW, 32'h1);
    expect_v("r15_rd1", S_RD1, 32'h48);
    expect_v("r15_wb", S_WB, 32'h100);
    step(); RF_WE_i = 1'b0;
    expect_v("r15_rd2", S_RD2, 32'hDEADBEEF);
    expect_v("r15_rd3", S_RD3, 32'hCAFEF00D);
    expect_v("r15_cnt", S_CNT, 32'h3);
    expect_v("r15_pcw_off", S_PCW, 32'h0);

    // Writes during reset are dropped and bypass is off
    step(); RST = 1'b1; RF_WE_i = 1'b1; A3_i = 4'd2; AluResult_i = 32'hFF;
    RA1_i = 4'd2; RA2_i = 4'd15;
    expect_v("rstwr_rd1", S_RD1, 32'h0);
    expect_v("rstwr_pc", S_RD2, 32'h48);
    expect_v("rstwr_pcw", S_PCW, 32'h0);
    step(); A3_i = 4'd15;
    expect_v("rstwr15_pcw", S_PCW, 32'h0);
    step(); RST = 1'b0; RF_WE_i = 1'b0; RA2_i = 4'd5;
    expect_v("rstwr_r2", S_RD1, 32'h0);
    expect_v("rstwr_r5", S_RD2, 32'h0);
    expect_v("rstwr_cnt", S_CNT, 32'h0);

    // First write after reset commits
    step(); RF_WE_i = 1'b1; A3_i = 4'd2; AluResult_i = 32'hAB;
    step(); RF_WE_i = 1'b0;
    expect_v("first_rd1", S_RD1, 32'hAB);
    expect_v("first_cnt", S_CNT, 32'h1);

    // Counter wrap: 65534 more writes reach 0xFFFF, one more wraps to 0
    for (int i = 0; i < 15; i++) model[i] = 32'h0;
    model[2] = 32'hAB;
    for (int i = 0; i < 65534; i++) begin
      step(); RF_WE_i = 1'b1; WBSelect_i = i[0];
      A3_i = i[3:0];
      AluResult_i = 32'hA5000000 | i;
      ReadData_i  = 32'h5A000000 | i;
      if (i[3:0] != 4'hF) model[i[3:0]] = i[0] ? (32'h5A000000 | i) : (32'hA5000000 | i);
    end
    step(); RF_WE_i = 1'b0;
    expect_v("wrap_ffff", S_CNT, 32'hFFFF);
    step(); RF_WE_i = 1'b1; WBSelect_i = 1'b0; A3_i = 4'd14; AluResult_i = 32'h600DF00D;
    model[14] = 32'h600DF00D;
    step(); RF_WE_i = 1'b0;
    expect_v("wrap_zero", S_CNT, 32'h0);
    for (int r = 0; r < 15; r++) begin
      RA1_i = r[3:0];
      expect_v($sformatf("readback_r%0d", r), S_RD1, model[r]);
      step();
    end

    for (int k = 0; k < 5 && sig_q.size() > 0; k++) step();
    if (sig_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", sig_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
